// File: rtl/hgcal_input_quantizer_if.sv
// rtl/hgcal_input_quantizer_if.sv - sample-in / frame-out bundle for the HGCAL input quantizer
//
// Signals (direction given for the slave = quantizer side):
//   s_valid   in   sample valid
//   s_ready   out  sample accepted when s_valid && s_ready
//   s_data    in   IN_W-bit trigger-cell energy
//   s_last    in   final sample of a frame
//   m_valid   out  assembled frame valid
//   m_ready   in   downstream accepts frame when m_valid && m_ready
//   m_data    out  N_FEAT*Q_W-bit frame, feature i at [i*Q_W +: Q_W]
//   err_frame out  one-cycle pulse when a frame is discarded
// Modports: slave (quantizer), master (producer/consumer side).
interface hgcal_input_quantizer_if #(
    parameter int N_FEAT = 48,
    parameter int IN_W   = 16,
    parameter int Q_W    = 2
);
    logic                   s_valid;
    logic                   s_ready;
    logic [IN_W-1:0]        s_data;
    logic                   s_last;
    logic                   m_valid;
    logic                   m_ready;
    logic [N_FEAT*Q_W-1:0]  m_data;
    logic                   err_frame;

    modport slave (
        input  s_valid, s_data, s_last, m_ready,
        output s_ready, m_valid, m_data, err_frame
    );

    modport master (
        output s_valid, s_data, s_last, m_ready,
        input  s_ready, m_valid, m_data, err_frame
    );
endinterface

// File: rtl/hgcal_input_quantizer.sv
// rtl/hgcal_input_quantizer.sv - quantizes trigger-cell energies and assembles double-buffered feature frames
//
// Ports:
//   clk  in   clock, rising edge
//   rst  in   asynchronous active-low reset
//   bus  hgcal_input_quantizer_if.slave (s_valid/s_ready/s_data/s_last in,
//        m_valid/m_ready/m_data out, err_frame pulse)
// Optional feature: define HGCAL_QUANT_SIGNED_EN to treat s_data as two's
// complement (negative energies quantize to 0). Default build is unsigned.
module hgcal_input_quantizer #(
    parameter int N_FEAT = 48,
    parameter int IN_W   = 16,
    parameter int Q_W    = 2,
    parameter int SHIFT  = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    hgcal_input_quantizer_if.slave  bus
);
    localparam int                VEC_W    = N_FEAT * Q_W;
    localparam int                IDX_W    = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N_FEAT - 1);
    localparam logic [IN_W-1:0]   QMAX     = IN_W'((1 << Q_W) - 1);

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        HOLD   = 2'd1,
        RESYNC = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [IDX_W-1:0]   idx;
    logic [VEC_W-1:0]   asm_buf;
    logic [VEC_W-1:0]   asm_nxt;
    logic [VEC_W-1:0]   m_data_r;
    logic               m_valid_r;
    logic               err_r;
    logic [IN_W-1:0]    shifted;
    logic [Q_W-1:0]     q;
    logic               s_ready_i;
    logic               accept;
    logic               free;
    logic               last_slot;
    logic               wr_slot;
    logic               xfer_fill;
    logic               xfer_hold;
    logic               idx_inc;
    logic               idx_clr;
    logic               err_set;

    // Ready depends on state only, so there is no combinational m_ready -> s_ready path.
    assign s_ready_i = (state != HOLD);
    assign accept    = bus.s_valid && s_ready_i;
    // A frame drained in the same cycle frees the output register.
    assign free      = !m_valid_r || bus.m_ready;
    assign last_slot = (idx == LAST_IDX);

    assign bus.s_ready   = s_ready_i;
    assign bus.m_valid   = m_valid_r;
    assign bus.m_data    = m_data_r;
    assign bus.err_frame = err_r;

    always_comb begin
        shifted = bus.s_data >> SHIFT;
        if (shifted > QMAX) begin
            q = QMAX[Q_W-1:0];
        end else begin
            q = shifted[Q_W-1:0];
        end
`ifdef HGCAL_QUANT_SIGNED_EN
        if (bus.s_data[IN_W-1]) begin
            q = '0;
        end
`endif
    end

    // Assembly vector including the current sample, so a completing frame can
    // go straight to the output register without an extra cycle.
    always_comb begin
        asm_nxt = asm_buf;
        asm_nxt[int'(idx) * Q_W +: Q_W] = q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            FILL: begin
                if (accept && last_slot) begin
                    if (!bus.s_last) begin
                        state_nxt = RESYNC;
                    end else if (!free) begin
                        state_nxt = HOLD;
                    end
                end
            end
            HOLD: begin
                if (free) begin
                    state_nxt = FILL;
                end
            end
            RESYNC: begin
                if (accept && bus.s_last) begin
                    state_nxt = FILL;
                end
            end
            default: state_nxt = FILL;
        endcase
    end

    always_comb begin
        wr_slot   = 1'b0;
        xfer_fill = 1'b0;
        xfer_hold = 1'b0;
        idx_inc   = 1'b0;
        idx_clr   = 1'b0;
        err_set   = 1'b0;
        case (state)
            FILL: begin
                if (accept) begin
                    wr_slot = 1'b1;
                    if (!last_slot && !bus.s_last) begin
                        idx_inc = 1'b1;
                    end else begin
                        idx_clr = 1'b1;
                        if (last_slot && bus.s_last) begin
                            xfer_fill = free;
                        end else begin
                            // early last or missing last: frame is discarded
                            err_set = 1'b1;
                        end
                    end
                end
            end
            HOLD: begin
                if (free) begin
                    xfer_hold = 1'b1;
                    idx_clr   = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx       <= '0;
            asm_buf   <= '0;
            m_data_r  <= '0;
            m_valid_r <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            err_r <= err_set;
            if (idx_inc) begin
                idx <= idx + 1'b1;
            end else if (idx_clr) begin
                idx <= '0;
            end
            if (wr_slot) begin
                asm_buf <= asm_nxt;
            end
            if (xfer_fill) begin
                m_data_r  <= asm_nxt;
                m_valid_r <= 1'b1;
            end else if (xfer_hold) begin
                m_data_r  <= asm_buf;
                m_valid_r <= 1'b1;
            end else if (bus.m_ready) begin
                m_valid_r <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_hgcal_input_quantizer.sv
// tb/tb_hgcal_input_quantizer.sv - directed self-checking bench for hgcal_input_quantizer
module tb_hgcal_input_quantizer;
    localparam int N_FEAT = 48;
    localparam int IN_W   = 16;
    localparam int Q_W    = 2;
    localparam int VEC_W  = N_FEAT * Q_W;
    localparam int NTBL   = 12;
`ifdef HGCAL_QUANT_SIGNED_EN
    localparam logic [1:0] NEG_Q = 2'd0;
`else
    localparam logic [1:0] NEG_Q = 2'd3;
`endif

    typedef struct packed {
        logic [15:0] d;
        logic [1:0]  q;
    } qvec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    hgcal_input_quantizer_if #(.N_FEAT(N_FEAT), .IN_W(IN_W), .Q_W(Q_W)) bus ();

    hgcal_input_quantizer #(
        .N_FEAT(N_FEAT), .IN_W(IN_W), .Q_W(Q_W), .SHIFT(6)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int               checks = 0;
    int               errors = 0;
    int               err_cnt = 0;
    logic [VEC_W-1:0] rx_q [$];
    logic             held = 1'b0;
    logic [VEC_W-1:0] held_data = '0;
    logic [15:0]      fr [N_FEAT];
    qvec_t            tbl [NTBL];

    // Output monitor: collect delivered frames, count error pulses, and
    // require m_data to stay put while a frame is stalled.
    always @(negedge clk) begin
        if (held && bus.m_valid) begin
            checks++;
            if (bus.m_data !== held_data) begin
                errors++;
                $display("FAIL hold_stable: got %h expected %h", bus.m_data, held_data);
            end
        end
        held      = bus.m_valid && !bus.m_ready;
        held_data = bus.m_data;
        if (bus.m_valid && bus.m_ready) rx_q.push_back(bus.m_data);
        if (bus.err_frame) err_cnt++;
    end

    task automatic check(input string name, input logic [VEC_W-1:0] act, input logic [VEC_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [15:0] d, input logic l);
        int guard = 0;
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        bus.s_last  = l;
        while (!bus.s_ready && guard < 500) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!bus.s_ready) begin
            checks++;
            errors++;
            $display("FAIL push_timeout: s_ready stuck at %0b required 1", bus.s_ready);
        end
        @(posedge clk); #1;
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    task automatic send_frame();
        for (int i = 0; i < N_FEAT; i++) push(fr[i], i == N_FEAT - 1);
    endtask

    task automatic wait_rx(input string name, input int n);
        int guard = 0;
        while (rx_q.size() < n && guard < 300) begin
            @(posedge clk); #2;
            guard++;
        end
        check(name, VEC_W'(rx_q.size()), VEC_W'(n));
    endtask

    function automatic logic [1:0] qref(input logic [15:0] d);
`ifdef HGCAL_QUANT_SIGNED_EN
        if (d[15]) return 2'd0;
`endif
        if (d >= 16'h00C0) return 2'd3;
        return d[7:6];
    endfunction

    function automatic logic [VEC_W-1:0] exp_vec();
        logic [VEC_W-1:0] v;
        v = '0;
        for (int i = 0; i < N_FEAT; i++) v[i*Q_W +: Q_W] = qref(fr[i]);
        return v;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [VEC_W-1:0] v;
        logic [VEC_W-1:0] vec_a;
        logic [VEC_W-1:0] vec_b;

        tbl[0]  = '{d: 16'h0000, q: 2'd0};
        tbl[1]  = '{d: 16'h0040, q: 2'd1};
        tbl[2]  = '{d: 16'h0080, q: 2'd2};
        tbl[3]  = '{d: 16'h00C0, q: 2'd3};
        tbl[4]  = '{d: 16'hFFFF, q: NEG_Q};
        tbl[5]  = '{d: 16'h00BF, q: 2'd2};
        tbl[6]  = '{d: 16'h003F, q: 2'd0};
        tbl[7]  = '{d: 16'h00FF, q: 2'd3};
        tbl[8]  = '{d: 16'h007F, q: 2'd1};
        tbl[9]  = '{d: 16'h8000, q: NEG_Q};
        tbl[10] = '{d: 16'h0100, q: 2'd3};
        tbl[11] = '{d: 16'h7FFF, q: 2'd3};

        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.s_last  = 1'b0;
        bus.m_ready = 1'b1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_m_valid", VEC_W'(bus.m_valid), '0);
        check("reset_m_data", bus.m_data, '0);
        check("reset_err_frame", VEC_W'(bus.err_frame), '0);
        check("reset_s_ready", VEC_W'(bus.s_ready), VEC_W'(1));
        rst = 1'b1;
        @(posedge clk); #1;

        // Basic frame: slot i = i%4, delivered the cycle after the last sample.
        for (int i = 0; i < N_FEAT; i++) fr[i] = 16'h0040 * 16'(i % 4);
        send_frame();
        check("t1_latency_m_valid", VEC_W'(bus.m_valid), VEC_W'(1));
        check("t1_m_data", bus.m_data, {12{8'hE4}});
        @(posedge clk); #1;
        check("t1_m_valid_drop", VEC_W'(bus.m_valid), '0);
        wait_rx("t1_rx_count", 1);
        if (rx_q.size() > 0) check("t1_rx_frame", rx_q[0], {12{8'hE4}});
        check("t1_err_cnt", VEC_W'(err_cnt), '0);
        rx_q.delete();

        // Quantization table, including saturation and sign handling.
        for (int i = 0; i < N_FEAT; i++) fr[i] = tbl[i % NTBL].d;
        send_frame();
        wait_rx("t2_rx_count", 1);
        if (rx_q.size() > 0) begin
            v = rx_q[0];
            for (int i = 0; i < N_FEAT; i++)
                check($sformatf("t2_slot%0d_d%h", i, tbl[i % NTBL].d),
                      VEC_W'(v[i*Q_W +: Q_W]), VEC_W'(tbl[i % NTBL].q));
        end
        rx_q.delete();

        // Backpressure: two frames queue up, second one parks in HOLD.
        bus.m_ready = 1'b0;
        for (int i = 0; i < N_FEAT; i++) fr[i] = 16'h0040 * 16'((i / 4) % 4);
        vec_a = exp_vec();
        send_frame();
        check("t3_a_valid", VEC_W'(bus.m_valid), VEC_W'(1));
        check("t3_a_data", bus.m_data, vec_a);
        for (int i = 0; i < N_FEAT; i++) fr[i] = 16'h0020 + 16'h0040 * 16'(i % 3);
        vec_b = exp_vec();
        send_frame();
        check("t3_s_ready_hold", VEC_W'(bus.s_ready), '0);
        check("t3_a_still_held", bus.m_data, vec_a);
        repeat (3) @(posedge clk);
        #1;
        check("t3_s_ready_still_low", VEC_W'(bus.s_ready), '0);
        check("t3_m_valid_held", VEC_W'(bus.m_valid), VEC_W'(1));
        bus.m_ready = 1'b1;
        wait_rx("t3_rx_count", 2);
        if (rx_q.size() > 1) begin
            check("t3_first_is_a", rx_q[0], vec_a);
            check("t3_second_is_b", rx_q[1], vec_b);
        end
        check("t3_s_ready_back", VEC_W'(bus.s_ready), VEC_W'(1));
        rx_q.delete();

        // Early last on sample #10.
        err_cnt = 0;
        for (int i = 0; i <= 10; i++) push(16'h00FF, i == 10);
        repeat (4) @(posedge clk);
        #2;
        check("t4_err_cnt", VEC_W'(err_cnt), VEC_W'(1));
        check("t4_no_frame", VEC_W'(rx_q.size()), '0);
        for (int i = 0; i < N_FEAT; i++) fr[i] = 16'h0040 * 16'((i + 1) % 4);
        v = exp_vec();
        send_frame();
        wait_rx("t4_rx_count", 1);
        if (rx_q.size() > 0) check("t4_next_frame", rx_q[0], v);
        rx_q.delete();

        // Missing last: 60 samples, last only on #59.
        err_cnt = 0;
        for (int i = 0; i < 60; i++) push(16'hFFFF, i == 59);
        repeat (4) @(posedge clk);
        #2;
        check("t5_err_cnt", VEC_W'(err_cnt), VEC_W'(1));
        check("t5_no_frame", VEC_W'(rx_q.size()), '0);
        for (int i = 0; i < N_FEAT; i++) fr[i] = 16'h0080 - 16'h0040 * 16'(i % 3);
        v = exp_vec();
        send_frame();
        wait_rx("t5_rx_count", 1);
        if (rx_q.size() > 0) check("t5_next_frame", rx_q[0], v);
        rx_q.delete();

        // Reset mid-frame while a frame is waiting on the output.
        bus.m_ready = 1'b0;
        for (int i = 0; i < N_FEAT; i++) fr[i] = 16'h00C0;
        send_frame();
        check("t6_pre_valid", VEC_W'(bus.m_valid), VEC_W'(1));
        for (int i = 0; i < 20; i++) push(16'h00FF, 1'b0);
        rst = 1'b0;
        #1;
        check("t6_rst_m_valid", VEC_W'(bus.m_valid), '0);
        check("t6_rst_m_data", bus.m_data, '0);
        @(posedge clk); #1;
        rst = 1'b1;
        bus.m_ready = 1'b1;
        check("t6_no_frame_lost_out", VEC_W'(rx_q.size()), '0);
        for (int i = 0; i < N_FEAT; i++) fr[i] = 16'h0040 * 16'((i / 2) % 4);
        v = exp_vec();
        send_frame();
        wait_rx("t6_rx_count", 1);
        if (rx_q.size() > 0) check("t6_frame_after_reset", rx_q[0], v);
        check("t6_err_cnt", VEC_W'(err_cnt), VEC_W'(1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
